// File: rtl/video_pattern_stream_gen.sv
// Video timing generator with a multi-channel test-pattern engine.
// Frames are framed by vsync/hsync/valid; all outputs lag the counters by one clock.
module video_pattern_stream_gen #(
    parameter int DATA_W    = 8,
    parameter int CHANNELS  = 3,
    parameter int H_SYNC    = 40,
    parameter int H_BACK    = 220,
    parameter int H_DISP    = 1280,
    parameter int H_FRONT   = 110,
    parameter int H_TOTAL   = 1650,
    parameter int V_SYNC    = 5,
    parameter int V_BACK    = 20,
    parameter int V_DISP    = 720,
    parameter int V_FRONT   = 5,
    parameter int V_TOTAL   = 750,
    parameter int CHK_SHIFT = 4,
    parameter int BAR_SHIFT = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vout_begin,
    input  logic                       cfg_cont,
    input  logic [2:0]                 cfg_mode,
    input  logic [DATA_W-1:0]          cfg_solid,
    output logic                       vout_vsync,
    output logic                       vout_hsync,
    output logic                       vout_valid,
    output logic [CHANNELS*DATA_W-1:0] vout_dat,
    output logic                       vout_busy,
    output logic                       vout_done,
    output logic [15:0]                frame_cnt,
    output logic [15:0]                vout_xres,
    output logic [15:0]                vout_yres
);

    localparam logic [15:0] HS_END = 16'(H_SYNC);
    localparam logic [15:0] HA0    = 16'(H_SYNC + H_BACK);
    localparam logic [15:0] HA1    = 16'(H_SYNC + H_BACK + H_DISP);
    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] VS_END = 16'(V_SYNC);
    localparam logic [15:0] VA0    = 16'(V_SYNC + V_BACK);
    localparam logic [15:0] VA1    = 16'(V_SYNC + V_BACK + V_DISP);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                      state_q;
    logic                        begin_q;
    logic                        armed_q;
    logic [15:0]                 col_q;
    logic [15:0]                 row_q;
    logic [2:0]                  mode_q;
    logic [DATA_W-1:0]           solid_q;
    logic [15:0]                 base_q;
    logic                        hsync_q;
    logic                        vsync_q;
    logic                        valid_q;
    logic [CHANNELS*DATA_W-1:0]  dat_q;
    logic                        done_q;
    logic [15:0]                 frame_cnt_q;

    logic                        run;
    logic                        start;
    logic                        col_last;
    logic                        row_last;
    logic                        frame_end;
    logic                        active;
    logic [15:0]                 x_d;
    logic [15:0]                 y_d;
    logic [CHANNELS*DATA_W-1:0]  dat_d;

    function automatic logic [CHANNELS*DATA_W-1:0] pattern(
        input logic [2:0]        mode,
        input logic [15:0]       x,
        input logic [15:0]       y,
        input logic [DATA_W-1:0] solid,
        input logic [15:0]       base
    );
        logic [CHANNELS*DATA_W-1:0] p;
        logic [31:0]                xw;
        logic [31:0]                yw;
        logic [31:0]                mw;
        logic [31:0]                bar;
        logic [DATA_W-1:0]          v;
        p   = '0;
        xw  = {16'd0, x};
        yw  = {16'd0, y};
        mw  = {16'd0, 16'(x + base)};
        bar = xw >> BAR_SHIFT;
        for (int c = 0; c < CHANNELS; c++) begin
            case (mode)
                3'd0:    v = solid;
                3'd1:    v = xw[DATA_W-1:0];
                3'd2:    v = yw[DATA_W-1:0];
                3'd3:    v = (xw[CHK_SHIFT] ^ yw[CHK_SHIFT]) ? '1 : '0;
                3'd4:    v = bar[c % 3] ? '1 : '0;
                3'd5:    v = mw[DATA_W-1:0];
                default: v = '0;
            endcase
            p[c*DATA_W +: DATA_W] = v;
        end
        return p;
    endfunction

    // armed_q blocks a start until vout_begin has been seen low after reset
    always_comb begin
        run       = (state_q == RUN);
        start     = vout_begin & ~begin_q & armed_q & ~run;
        col_last  = (col_q == H_LAST);
        row_last  = (row_q == V_LAST);
        frame_end = run & col_last & row_last;
        active    = run & (col_q >= HA0) & (col_q < HA1) & (row_q >= VA0) & (row_q < VA1);
        x_d       = col_q - HA0;
        y_d       = row_q - VA0;
        dat_d     = active ? pattern(mode_q, x_d, y_d, solid_q, base_q) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            begin_q     <= 1'b0;
            armed_q     <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= '0;
            solid_q     <= '0;
            base_q      <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            valid_q     <= 1'b0;
            dat_q       <= '0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            begin_q <= vout_begin;
            armed_q <= armed_q | ~vout_begin;
            hsync_q <= run & (col_q < HS_END);
            vsync_q <= run & (row_q < VS_END);
            valid_q <= active;
            dat_q   <= dat_d;
            done_q  <= frame_end;
            if (frame_end) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        col_q   <= '0;
                        row_q   <= '0;
                        mode_q  <= cfg_mode;
                        solid_q <= cfg_solid;
                        base_q  <= frame_cnt_q;
                    end
                end
                RUN: begin
                    if (col_last) begin
                        col_q <= '0;
                        if (row_last) begin
                            row_q <= '0;
                            if (cfg_cont) begin
                                // back-to-back frame: base tracks the count being bumped now
                                mode_q  <= cfg_mode;
                                solid_q <= cfg_solid;
                                base_q  <= frame_cnt_q + 16'd1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            row_q <= row_q + 16'd1;
                        end
                    end else begin
                        col_q <= col_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vout_hsync = hsync_q;
    assign vout_vsync = vsync_q;
    assign vout_valid = valid_q;
    assign vout_dat   = dat_q;
    assign vout_busy  = (state_q == RUN);
    assign vout_done  = done_q;
    assign frame_cnt  = frame_cnt_q;
    assign vout_xres  = 16'(H_DISP);
    assign vout_yres  = 16'(V_DISP);

endmodule

// File: tb/tb_video_pattern_stream_gen.sv
// Directed bench for video_pattern_stream_gen on a 14x7 timing with 8x4 active area.
module tb_video_pattern_stream_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vout_begin = 1'b0;
    logic        cfg_cont = 1'b0;
    logic [2:0]  cfg_mode = 3'd0;
    logic [7:0]  cfg_solid = 8'd0;
    logic        vout_vsync, vout_hsync, vout_valid, vout_busy, vout_done;
    logic [23:0] vout_dat;
    logic [15:0] frame_cnt, vout_xres, vout_yres;

    video_pattern_stream_gen #(
        .DATA_W(8), .CHANNELS(3),
        .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2), .H_TOTAL(14),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1), .V_TOTAL(7),
        .CHK_SHIFT(1), .BAR_SHIFT(1)
    ) dut (
        .clk(clk), .rst(rst), .vout_begin(vout_begin), .cfg_cont(cfg_cont),
        .cfg_mode(cfg_mode), .cfg_solid(cfg_solid),
        .vout_vsync(vout_vsync), .vout_hsync(vout_hsync), .vout_valid(vout_valid),
        .vout_dat(vout_dat), .vout_busy(vout_busy), .vout_done(vout_done),
        .frame_cnt(frame_cnt), .vout_xres(vout_xres), .vout_yres(vout_yres)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          run;
        int          f;
        int          y;
        int          x;
        logic [23:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [23:0] cap [4][4][8];
    int tests = 0;
    int fails = 0;
    int busy_cnt, busy_rise, valid_cnt, run_cnt, bad_run, hs_cnt, vs_cnt, done_cnt, leak;
    int done_t [4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drives a start edge, then samples every falling edge for ncyc cycles.
    task automatic run_frame(input int ncyc, input int action);
        int f, l, p;
        logic pb, pv;
        busy_cnt = 0; busy_rise = 0; valid_cnt = 0; run_cnt = 0; bad_run = 0;
        hs_cnt = 0; vs_cnt = 0; done_cnt = 0; leak = 0;
        for (int k = 0; k < 4; k++) done_t[k] = -1;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 8; c++) cap[a][b][c] = 24'hDEADBE;
        f = 0; l = 0; p = 0; pb = vout_busy; pv = 1'b0;
        vout_begin = 1'b1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            vout_begin = 1'b0;
            if (action == 1 && i == 20) begin cfg_mode = 3'd7; cfg_solid = 8'h00; end
            if (action == 2 && i == 30) vout_begin = 1'b1;
            if (action == 3 && i == 216) cfg_cont = 1'b0;
            if (vout_busy) busy_cnt++;
            if (vout_busy && !pb) busy_rise++;
            if (vout_hsync) hs_cnt++;
            if (vout_vsync) vs_cnt++;
            if (vout_valid) begin
                valid_cnt++;
                if (f < 4 && l < 4 && p < 8) cap[f][l][p] = vout_dat;
                p++;
            end else begin
                if (pv) begin
                    run_cnt++;
                    if (p != 8) bad_run++;
                    l++;
                    p = 0;
                end
                if (vout_dat != 24'd0) leak++;
            end
            if (vout_done) begin
                if (done_cnt < 4) done_t[done_cnt] = i;
                done_cnt++;
                f++;
                l = 0;
            end
            pv = vout_valid;
            pb = vout_busy;
        end
    endtask

    task automatic check_table(input int run_id);
        foreach (tbl[k]) begin
            if (tbl[k].run == run_id)
                check($sformatf("run%0d f%0d y%0d x%0d", run_id, tbl[k].f, tbl[k].y, tbl[k].x),
                      {8'd0, cap[tbl[k].f][tbl[k].y][tbl[k].x]}, {8'd0, tbl[k].exp});
        end
    endtask

    task automatic check_single_frame(input string nm);
        check({nm, " busy cycles"}, busy_cnt, 98);
        check({nm, " busy rises"}, busy_rise, 1);
        check({nm, " valid cycles"}, valid_cnt, 32);
        check({nm, " valid runs"}, run_cnt, 4);
        check({nm, " short runs"}, bad_run, 0);
        check({nm, " done pulses"}, done_cnt, 1);
        check({nm, " data outside valid"}, leak, 0);
    endtask

    initial begin
        int idle_busy;
        // run 1: horizontal ramp
        tbl.push_back('{1, 0, 0, 0, 24'h000000});
        tbl.push_back('{1, 0, 0, 7, 24'h070707});
        tbl.push_back('{1, 0, 1, 2, 24'h020202});
        tbl.push_back('{1, 0, 3, 5, 24'h050505});
        // run 2: checker, 2-pixel squares
        tbl.push_back('{2, 0, 0, 0, 24'h000000});
        tbl.push_back('{2, 0, 0, 1, 24'h000000});
        tbl.push_back('{2, 0, 0, 2, 24'hFFFFFF});
        tbl.push_back('{2, 0, 0, 3, 24'hFFFFFF});
        tbl.push_back('{2, 0, 0, 4, 24'h000000});
        tbl.push_back('{2, 0, 0, 6, 24'hFFFFFF});
        tbl.push_back('{2, 0, 1, 2, 24'hFFFFFF});
        tbl.push_back('{2, 0, 2, 0, 24'hFFFFFF});
        tbl.push_back('{2, 0, 2, 2, 24'h000000});
        tbl.push_back('{2, 0, 3, 0, 24'hFFFFFF});
        // run 3: colour bars, {ch2,ch1,ch0}
        tbl.push_back('{3, 0, 1, 0, 24'h000000});
        tbl.push_back('{3, 0, 1, 2, 24'h0000FF});
        tbl.push_back('{3, 0, 1, 5, 24'h00FF00});
        tbl.push_back('{3, 0, 1, 7, 24'h00FFFF});
        // run 4: solid with mid-frame config change
        tbl.push_back('{4, 0, 0, 0, 24'h5A5A5A});
        tbl.push_back('{4, 0, 3, 7, 24'h5A5A5A});
        // run 5: reserved mode
        tbl.push_back('{5, 0, 1, 3, 24'h000000});
        // run 6: moving ramp, continuous, frame_cnt restarts at 0
        tbl.push_back('{6, 0, 0, 0, 24'h000000});
        tbl.push_back('{6, 0, 3, 7, 24'h070707});
        tbl.push_back('{6, 1, 0, 0, 24'h010101});
        tbl.push_back('{6, 1, 2, 7, 24'h080808});
        tbl.push_back('{6, 2, 1, 3, 24'h050505});

        #12;
        check("reset busy", vout_busy, 0);
        check("reset valid/sync/done", {vout_valid, vout_hsync, vout_vsync, vout_done}, 0);
        check("reset dat", vout_dat, 0);
        check("reset frame_cnt", frame_cnt, 0);
        check("xres", vout_xres, 8);
        check("yres", vout_yres, 4);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);

        cfg_mode = 3'd1;
        run_frame(120, 0);
        check_single_frame("ramp");
        check("ramp hsync cycles", hs_cnt, 14);
        check("ramp vsync cycles", vs_cnt, 14);
        check("ramp done position", done_t[0], 99);
        check("ramp frame_cnt", frame_cnt, 1);
        check("ramp busy after", vout_busy, 0);
        check_table(1);

        cfg_mode = 3'd3;
        run_frame(110, 0);
        check_single_frame("checker");
        check_table(2);

        cfg_mode = 3'd4;
        run_frame(110, 0);
        check_single_frame("bars");
        check_table(3);

        cfg_mode = 3'd0; cfg_solid = 8'h5A;
        run_frame(110, 1);
        check_single_frame("solid");
        check_table(4);

        cfg_mode = 3'd6;
        run_frame(110, 0);
        check_single_frame("reserved");
        check_table(5);

        cfg_mode = 3'd1;
        run_frame(250, 2);
        check_single_frame("repulse");
        check("repulse frame_cnt", frame_cnt, 6);

        // asynchronous reset in the middle of an active line
        vout_begin = 1'b1;
        @(negedge clk); vout_begin = 1'b0;
        repeat (49) @(negedge clk);
        check("pre-reset valid", vout_valid, 1);
        check("pre-reset busy", vout_busy, 1);
        #2 rst = 1'b1; vout_begin = 1'b1;
        #1;
        check("async reset busy", vout_busy, 0);
        check("async reset valid/sync/done", {vout_valid, vout_hsync, vout_vsync, vout_done}, 0);
        check("async reset dat", vout_dat, 0);
        check("async reset frame_cnt", frame_cnt, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (vout_busy) idle_busy++;
        end
        check("begin held through reset", idle_busy, 0);
        vout_begin = 1'b0;
        repeat (3) @(negedge clk);

        cfg_mode = 3'd5; cfg_cont = 1'b1;
        run_frame(330, 3);
        check("cont busy cycles", busy_cnt, 294);
        check("cont busy rises", busy_rise, 1);
        check("cont done pulses", done_cnt, 3);
        check("cont done spacing 1", done_t[1] - done_t[0], 98);
        check("cont done spacing 2", done_t[2] - done_t[1], 98);
        check("cont valid cycles", valid_cnt, 96);
        check("cont frame_cnt", frame_cnt, 3);
        check("cont busy after", vout_busy, 0);
        check_table(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
